disp_num_ctrl: RTL and testbench

- Sequencing controller that converts a signed binary result into the eight digit codes, digit enables and decimal-point enables used by the 8-digit segment display driver.
- Sits between the calculator datapath and the display driver.
- Runs a multi-cycle binary-to-BCD conversion (shift-add-3), then formats the result:
  - leading-zero blanking
  - minus-sign placement
  - decimal point
  - overflow/error indication.
- The display-facing outputs update atomically. They hold their old value until formatting completes.

---
 rtl/disp_num_ctrl.sv | 175 +++++++++++++++++
 tb/tb_disp_num_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/disp_num_ctrl.sv
// Signed binary -> 8-digit display formatter (shift-add-3 BCD, blanking, sign, dp, overflow).
// Optional error blink enabled by defining DISP_BLINK_EN.
module disp_num_ctrl #(
  parameter int IN_W      = 28,
  parameter int BLINK_DIV = 6000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [IN_W-1:0] value,
  input  logic [3:0]      dp_pos,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      dat_1,
  output logic [3:0]      dat_2,
  output logic [3:0]      dat_3,
  output logic [3:0]      dat_4,
  output logic [3:0]      dat_5,
  output logic [3:0]      dat_6,
  output logic [3:0]      dat_7,
  output logic [3:0]      dat_8,
  output logic [7:0]      dat_en,
  output logic [7:0]      dot_en
);

  typedef enum logic [1:0] {IDLE, ABS, CONV, FMT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] mag_q;
  logic [35:0]     bcd_q;
  logic [2:0]      dp_q;
  logic            sign_q;
  logic [4:0]      cnt_q;

  logic [7:0][3:0] dat_r;
  logic [7:0]      en_r;

  logic [35:0]     bcd_adj;
  logic [3:0]      sig, m, dp1;
  logic            neg, ovf;
  logic [7:0][3:0] f_dat;
  logic [7:0]      f_en, f_dot;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ABS;
      ABS:     state_nxt = CONV;
      CONV:    if (cnt_q == 5'd1) state_nxt = FMT;
      FMT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 9; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Formatting works off the finished BCD so outputs change in one cycle.
  always_comb begin
    sig = 4'd1;
    for (int i = 0; i < 9; i++)
      if (bcd_q[4*i +: 4] != 4'd0) sig = 4'(i + 1);
    dp1 = {1'b0, dp_q} + 4'd1;
    m   = (sig > dp1) ? sig : dp1;
    neg = sign_q && (bcd_q != 36'd0);
    ovf = neg ? (m >= 4'd8) : (m >= 4'd9);
    f_dot = (dp_q != 3'd0) ? (8'd1 << dp_q) : 8'h00;
    f_dat = '0;
    f_en  = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < m) begin
        f_en[i]  = 1'b1;
        f_dat[i] = bcd_q[4*i +: 4];
      end else if (neg && (4'(i) == m)) begin
        f_en[i]  = 1'b1;
        f_dat[i] = 4'hA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mag_q  <= '0;
      bcd_q  <= '0;
      dp_q   <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      dat_r  <= '0;
      en_r   <= 8'h01;
      dot_en <= 8'h00;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (load) begin
          mag_q <= value;
          dp_q  <= (dp_pos > 4'd7) ? 3'd0 : dp_pos[2:0];
          busy  <= 1'b1;
        end
        ABS: begin
          sign_q <= mag_q[IN_W-1];
          mag_q  <= mag_q[IN_W-1] ? -mag_q : mag_q;
          bcd_q  <= '0;
          cnt_q  <= 5'(IN_W);
        end
        CONV: begin
          {bcd_q, mag_q} <= {bcd_adj[34:0], mag_q, 1'b0};
          cnt_q          <= cnt_q - 5'd1;
        end
        FMT: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (ovf) begin
            err    <= 1'b1;
            dat_r  <= {28'd0, 4'hE};
            en_r   <= 8'h01;
            dot_en <= 8'h00;
          end else begin
            err    <= 1'b0;
            dat_r  <= f_dat;
            en_r   <= f_en;
            dot_en <= f_dot;
          end
        end
        default: ;
      endcase
    end
  end

  assign dat_8 = dat_r[0];
  assign dat_7 = dat_r[1];
  assign dat_6 = dat_r[2];
  assign dat_5 = dat_r[3];
  assign dat_4 = dat_r[4];
  assign dat_3 = dat_r[5];
  assign dat_2 = dat_r[6];
  assign dat_1 = dat_r[7];

`ifdef DISP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic          err_rise;

  assign err_rise = (state == FMT) && ovf && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (err_rise || !err) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign dat_en = (err && blink_off) ? 8'h00 : en_r;
`else
  assign dat_en = en_r;
`endif

endmodule

// File: tb/tb_disp_num_ctrl.sv
// Directed bench for disp_num_ctrl: expected displays queued at load, checked on done.
module tb_disp_num_ctrl;

  localparam int IN_W = 28;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load = 1'b0;
  logic [IN_W-1:0] value = '0;
  logic [3:0]      dp_pos = '0;
  logic            busy, done, err;
  logic [3:0]      dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8;
  logic [7:0]      dat_en, dot_en;

  typedef struct packed {
    logic [31:0] dat;
    logic [7:0]  en;
    logic [7:0]  dot;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  disp_num_ctrl #(.IN_W(IN_W), .BLINK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_pos(dp_pos),
    .busy(busy), .done(done), .err(err),
    .dat_1(dat_1), .dat_2(dat_2), .dat_3(dat_3), .dat_4(dat_4),
    .dat_5(dat_5), .dat_6(dat_6), .dat_7(dat_7), .dat_8(dat_8),
    .dat_en(dat_en), .dot_en(dot_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dats();
    return {dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("dat", 64'(dats()), 64'(e.dat));
        chk("dat_en", 64'(dat_en), 64'(e.en));
        chk("dot_en", 64'(dot_en), 64'(e.dot));
        chk("err", 64'(err), 64'(e.err));
        chk("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  // Drive a load on the next edge; edge after that plus 30 carries done.
  task automatic do_load(input logic [IN_W-1:0] v, input logic [3:0] dp, input logic push,
                         input logic [31:0] d, input logic [7:0] en, input logic [7:0] dot,
                         input logic e);
    exp_t x;
    load = 1'b1; value = v; dp_pos = dp;
    if (push) begin
      x.dat = d; x.en = en; x.dot = dot; x.err = e; x.cyc = cyc + 31;
      sb.push_back(x);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dat", 64'(dats()), 64'd0);
    chk("rst_en", 64'(dat_en), 64'h01);
    chk("rst_dot", 64'(dot_en), 64'h00);
    chk("rst_flags", 64'({busy, done, err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_load(28'd1234, 4'd0, 1'b1, 32'h0000_1234, 8'h0F, 8'h00, 1'b0);
    chk("busy_after_load", 64'(busy), 64'd1);
    wait_idle("to_1234");

    do_load(-28'sd5, 4'd2, 1'b1, 32'h0000_A005, 8'h0F, 8'h04, 1'b0);
    wait_idle("to_neg5");

    do_load(-28'sd9999999, 4'd0, 1'b1, 32'hA999_9999, 8'hFF, 8'h00, 1'b0);
    wait_idle("to_neg9999999");

    do_load(-28'sd1, 4'd7, 1'b1, 32'h0000_000E, 8'h01, 8'h00, 1'b1);
    wait_idle("to_neg1_dp7");

    do_load(28'd100000000, 4'd0, 1'b1, 32'h0000_000E, 8'h01, 8'h00, 1'b1);
    wait_idle("to_1e8");
    chk("err_held", 64'(err), 64'd1);

    do_load(28'd7, 4'd0, 1'b1, 32'h0000_0007, 8'h01, 8'h00, 1'b0);
    wait_idle("to_7");

    // Second load while busy must be dropped.
    do_load(28'd42, 4'd1, 1'b1, 32'h0000_0042, 8'h03, 8'h02, 1'b0);
    repeat (4) @(negedge clk);
    do_load(28'd99, 4'd0, 1'b0, '0, '0, '0, 1'b0);
    wait_idle("to_42");
    repeat (35) @(negedge clk);

    // Load landing in the done cycle is accepted; dp_pos > 7 acts as 0.
    do_load(28'd12345678, 4'd3, 1'b1, 32'h1234_5678, 8'hFF, 8'h08, 1'b0);
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", 64'(done), 64'd1);
    end
    do_load(-28'sd3, 4'd9, 1'b1, 32'h0000_00A3, 8'h03, 8'h00, 1'b0);
    wait_idle("to_done_cycle_load");

    do_load(28'd0, 4'd5, 1'b1, 32'h0000_0000, 8'h3F, 8'h20, 1'b0);
    wait_idle("to_zero_dp5");

    // Reset mid-conversion: immediate reset values and no done afterwards.
    do_load(28'd55, 4'd0, 1'b0, '0, '0, '0, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dat", 64'(dats()), 64'd0);
    chk("arst_en", 64'(dat_en), 64'h01);
    chk("arst_dot", 64'(dot_en), 64'h00);
    chk("arst_flags", 64'({busy, done, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    do_load(-28'sd134217728, 4'd0, 1'b1, 32'h0000_000E, 8'h01, 8'h00, 1'b1);
    wait_idle("to_min_neg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
